// File: rtl/clkdiv_pkg.sv
// Shared types and constants for the programmable clock-enable generator.
package clkdiv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } clkdiv_state_t;

  localparam int MIN_DIV = 2;

endpackage

// File: rtl/clkdiv_cfg_slot.sv
// One-entry holding register for an offered divisor; rejects illegal values
// and stays full until the FSM takes the divisor at a period boundary.
module clkdiv_cfg_slot
  import clkdiv_pkg::*;
#(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_valid,
  input  logic [CNT_WIDTH-1:0] cfg_div,
  input  logic                 take,
  output logic                 cfg_ready,
  output logic                 cfg_err,
  output logic                 pend_v,
  output logic [CNT_WIDTH-1:0] pend_div
);

  logic accept;
  logic legal;

  assign cfg_ready = !pend_v;
  assign accept    = cfg_valid && cfg_ready;
  assign legal     = (cfg_div >= CNT_WIDTH'(MIN_DIV));

  // take only fires while pend_v is set, accept only while it is clear,
  // so the two never collide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_v   <= 1'b0;
      pend_div <= '0;
      cfg_err  <= 1'b0;
    end else begin
      cfg_err <= accept && !legal;
      if (accept && legal) begin
        pend_div <= cfg_div;
        pend_v   <= 1'b1;
      end else if (take) begin
        pend_v <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/clkdiv_ctrl.sv
// Programmable square-wave divider with a tick on each rising edge; divisor
// updates land only on period boundaries so no period is ever shortened.
module clkdiv_ctrl
  import clkdiv_pkg::*;
#(
  parameter int CNT_WIDTH   = 8,
  parameter int DEFAULT_DIV = 100
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 cfg_valid,
  input  logic [CNT_WIDTH-1:0] cfg_div,
  output logic                 cfg_ready,
  output logic                 cfg_err,
  output logic                 divclk,
  output logic                 tick,
  output logic                 busy
);

  clkdiv_state_t        state;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] div_q;
  logic [CNT_WIDTH-1:0] pend_div;
  logic                 pend_v;
  logic                 take;
  logic [CNT_WIDTH:0]   half_hi;
  logic [CNT_WIDTH:0]   half_lo;
  logic                 hi_end;
  logic                 lo_end;

  // Extra bit keeps ceil(N/2) correct when N is the largest representable value.
  assign half_hi = ({1'b0, div_q} + (CNT_WIDTH+1)'(1)) >> 1;
  assign half_lo = {1'b0, div_q} >> 1;
  assign hi_end  = ({1'b0, cnt} == half_hi);
  assign lo_end  = ({1'b0, cnt} == half_lo);
  assign take    = pend_v && ((state == ST_IDLE) || ((state == ST_LOW) && lo_end));

  clkdiv_cfg_slot #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_cfg_slot (
    .clk      (clk),
    .rst      (rst),
    .cfg_valid(cfg_valid),
    .cfg_div  (cfg_div),
    .take     (take),
    .cfg_ready(cfg_ready),
    .cfg_err  (cfg_err),
    .pend_v   (pend_v),
    .pend_div (pend_div)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      div_q  <= CNT_WIDTH'(DEFAULT_DIV);
      cnt    <= CNT_WIDTH'(1);
      divclk <= 1'b0;
      tick   <= 1'b0;
      busy   <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (take) div_q <= pend_div;
      case (state)
        ST_IDLE: begin
          if (en) begin
            state  <= ST_HIGH;
            divclk <= 1'b1;
            tick   <= 1'b1;
            busy   <= 1'b1;
            cnt    <= CNT_WIDTH'(1);
          end
        end
        ST_HIGH: begin
          if (hi_end) begin
            state  <= ST_LOW;
            divclk <= 1'b0;
            cnt    <= CNT_WIDTH'(1);
          end else begin
            cnt <= cnt + CNT_WIDTH'(1);
          end
        end
        ST_LOW: begin
          if (lo_end) begin
            cnt <= CNT_WIDTH'(1);
            if (en) begin
              state  <= ST_HIGH;
              divclk <= 1'b1;
              tick   <= 1'b1;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + CNT_WIDTH'(1);
          end
        end
        default: begin
          state  <= ST_IDLE;
          divclk <= 1'b0;
          busy   <= 1'b0;
          cnt    <= CNT_WIDTH'(1);
        end
      endcase
    end
  end

endmodule
